// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the sequence-detection path: serializer state
// encoding and the pattern shared with fsm_seq_det and its benches.
package fsm_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic [4:0] SEQ_PATTERN = 5'b10010;
  localparam int         SEQ_LEN     = 5;

endpackage

// File: rtl/fsm_seq_shreg.sv
// Loadable WIDTH-bit shift register feeding the serializer. Bit order is
// MSB first by default, LSB first when FSM_SER_LSB_FIRST_EN is defined.
module fsm_seq_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit_nxt
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] sh_shifted;

`ifdef FSM_SER_LSB_FIRST_EN
  assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
  assign bit_nxt    = sh_nxt[0];
`else
  assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
  assign bit_nxt    = sh_nxt[WIDTH-1];
`endif

  // bit_nxt is the head of the register as it will be after this edge,
  // which is exactly the bit the serializer registers onto the wire.
  always_comb begin
    if (load)       sh_nxt = din;
    else if (shift) sh_nxt = sh_shifted;
    else            sh_nxt = sh;
  end

  // NOTE: the data register is cleared on reset even though its content is
  // a don't-care in IDLE; it keeps reset state fully deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= sh_nxt;
  end

endmodule

// File: rtl/fsm_seq_ser.sv
// Parallel-to-serial front end for fsm_seq_det: valid/ready word input,
// gap-free registered bit stream out. Bit order set by FSM_SER_LSB_FIRST_EN.
module fsm_seq_ser
  import fsm_seq_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_vld,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          data_r, data_n;
  logic          vld_r, vld_n;
  logic          load, shift, bit_nxt, accept;

  fsm_seq_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .din     (in_data),
    .bit_nxt (bit_nxt)
  );

  // Ready on the last bit as well as in IDLE, so back-to-back words abut.
  assign in_ready = !rst && (state == IDLE || cnt == LAST);
  assign accept   = in_valid && in_ready;

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    shift   = 1'b0;
    data_n  = IDLE_BIT;
    vld_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          load    = 1'b1;
          cnt_n   = '0;
          data_n  = bit_nxt;
          vld_n   = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          if (accept) begin
            load   = 1'b1;
            cnt_n  = '0;
            data_n = bit_nxt;
            vld_n  = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          shift  = 1'b1;
          cnt_n  = cnt + CW'(1);
          data_n = bit_nxt;
          vld_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_r <= IDLE_BIT;
      vld_r  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data_r <= data_n;
      vld_r  <= vld_n;
    end
  end

  assign data     = data_r;
  assign data_vld = vld_r;
  assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_fsm_seq_ser.sv
// Self-checking bench for fsm_seq_ser: reset checks, a fixed vector table for
// the back-to-back stream, hand sequences, and random traffic vs a bit queue.
module tb_fsm_seq_ser;

  localparam int   W        = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         data;
  logic         data_vld;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of bits still to appear on the wire, head = current bit.
  bit q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_data;
    logic         e_vld;
    logic         e_rdy;
  } vec_t;

  vec_t tbl[17];

  fsm_seq_ser #(.WIDTH(W), .IDLE_BIT(IDLE_BIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .data_vld (data_vld),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit nth_bit(input logic [W-1:0] w, input int i);
`ifdef FSM_SER_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  task automatic check_model(input string tag);
    logic ev, ed;
    ev = (q.size() > 0);
    ed = ev ? q[0] : IDLE_BIT;
    check({tag, ".data"},     32'(data),     32'(ed));
    check({tag, ".data_vld"}, 32'(data_vld), 32'(ev));
    check({tag, ".busy"},     32'(busy),     32'(ev));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!rst && q.size() <= 1));
  endtask

  // Apply inputs, clock once, advance the reference, compare.
  task automatic cycle(input logic v, input logic [W-1:0] d, input string tag);
    bit acc;
    in_valid = v;
    in_data  = d;
    acc = v && !rst && (q.size() <= 1);
    @(posedge clk);
    #1;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) for (int i = 0; i < W; i++) q.push_back(nth_bit(d, i));
    check_model(tag);
  endtask

  initial begin
    logic [15:0] stream;

    // Both bytes are bit-palindromes, so this stream holds for either order.
    stream = 16'hA53C;
    for (int k = 0; k < 16; k++) begin
      tbl[k].v      = (k <= 8);
      tbl[k].d      = (k == 0) ? 8'hA5 : 8'h3C;
      tbl[k].e_data = stream[15-k];
      tbl[k].e_vld  = 1'b1;
      tbl[k].e_rdy  = (k == 7 || k == 15);
    end
    tbl[16] = '{1'b0, 8'h00, IDLE_BIT, 1'b0, 1'b1};

    // Reset with a word offered: nothing may be accepted, ready held low.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    check("rst.data",     32'(data),     32'(IDLE_BIT));
    check("rst.data_vld", 32'(data_vld), 32'd0);
    check("rst.busy",     32'(busy),     32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.data_vld", 32'(data_vld), 32'd0);
    check("rst_hold.in_ready", 32'(in_ready), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.data_vld", 32'(data_vld), 32'd0);

    // Back-to-back A5, 3C with in_valid held and in_data changing mid-word.
    for (int k = 0; k < 17; k++) begin
      in_valid = tbl[k].v;
      in_data  = tbl[k].d;
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].data", k),     32'(data),     32'(tbl[k].e_data));
      check($sformatf("tbl[%0d].data_vld", k), 32'(data_vld), 32'(tbl[k].e_vld));
      check($sformatf("tbl[%0d].busy", k),     32'(busy),     32'(tbl[k].e_vld));
      check($sformatf("tbl[%0d].in_ready", k), 32'(in_ready), 32'(tbl[k].e_rdy));
    end
    q.delete();

    // Async reset during bit 3 of 8'hFF, then 8'h81 must come out whole.
    cycle(1'b1, 8'hFF, "ff.acc");
    for (int i = 1; i <= 3; i++) cycle(1'b0, 8'h00, "ff.bit");
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check("midrst.data",     32'(data),     32'(IDLE_BIT));
    check("midrst.data_vld", 32'(data_vld), 32'd0);
    check("midrst.busy",     32'(busy),     32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check_model("midrst.rel");
    cycle(1'b1, 8'h81, "w81.acc");
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, "w81.bit");

    // Single-cycle in_valid pulse while busy and not ready: must be ignored.
    cycle(1'b1, 8'h92, "pulse.acc");
    cycle(1'b0, 8'h00, "pulse.bit");
    cycle(1'b0, 8'h00, "pulse.bit");
    cycle(1'b1, 8'h6E, "pulse.ignored");
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, "pulse.tail");
    check("pulse.idle_vld", 32'(data_vld), 32'd0);

    // Random traffic against the bit-queue reference.
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 3) != 0), W'($urandom), "rand");
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
